// File: rtl/bus_dma_master_if.sv
// Bus port between a DMA master and the two-master arbiter/decoder.
// The master drives request, direction, address and write data; the bus returns grant and read data.
interface bus_dma_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              m_req;
    logic              m_wr;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_dout;
    logic              m_grant;
    logic [DATA_W-1:0] m_din;

    modport master (
        output m_req,
        output m_wr,
        output m_address,
        output m_dout,
        input  m_grant,
        input  m_din
    );

    modport slave (
        input  m_req,
        input  m_wr,
        input  m_address,
        input  m_dout,
        output m_grant,
        output m_din
    );
endinterface

// File: rtl/bus_dma_master.sv
// Block-copy DMA master: reads length words from src and writes them to dst, one word at a time.
// Every output is a register loaded from the next-state decode, so nothing combinational leaves the block.
module bus_dma_master #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    bus_dma_master_if.master  bus,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_src, w_src_nxt;
    logic [ADDR_W-1:0] r_dst, w_dst_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_buf, w_buf_nxt;

    logic              r_m_req, w_m_req_nxt;
    logic              r_m_wr, w_m_wr_nxt;
    logic [ADDR_W-1:0] r_m_address, w_m_address_nxt;
    logic [DATA_W-1:0] r_m_dout, w_m_dout_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    // Next-state logic, then output decode of the state being entered
    always_comb begin
        w_state_nxt     = r_state;
        w_src_nxt       = r_src;
        w_dst_nxt       = r_dst;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_buf_nxt       = r_buf;
        w_m_address_nxt = '0;
        w_m_dout_nxt    = '0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src_nxt   = src_addr;
                    w_dst_nxt   = dst_addr;
                    w_len_nxt   = length;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (length == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.m_grant) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (bus.m_grant) begin
                    w_buf_nxt   = bus.m_din;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.m_grant) begin
                    w_cnt_nxt   = r_cnt + LEN_W'(1);
                    w_state_nxt = (w_cnt_nxt == r_len) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_m_req_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_READ) ||
                      (w_state_nxt == S_WRITE);
        w_m_wr_nxt  = (w_state_nxt == S_WRITE);
        w_busy_nxt  = w_m_req_nxt;
        w_done_nxt  = (w_state_nxt == S_DONE);

        // Addresses wrap modulo 2^ADDR_W
        case (w_state_nxt)
            S_REQ, S_READ: begin
                w_m_address_nxt = w_src_nxt + ADDR_W'(w_cnt_nxt);
            end
            S_WRITE: begin
                w_m_address_nxt = w_dst_nxt + ADDR_W'(w_cnt_nxt);
                w_m_dout_nxt    = w_buf_nxt;
            end
            default: begin
                w_m_address_nxt = '0;
                w_m_dout_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_m_req     <= 1'b0;
            r_m_wr      <= 1'b0;
            r_m_address <= '0;
            r_m_dout    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_buf       <= w_buf_nxt;
            r_m_req     <= w_m_req_nxt;
            r_m_wr      <= w_m_wr_nxt;
            r_m_address <= w_m_address_nxt;
            r_m_dout    <= w_m_dout_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.m_req     = r_m_req;
    assign bus.m_wr      = r_m_wr;
    assign bus.m_address = r_m_address;
    assign bus.m_dout    = r_m_dout;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: a memory slave with a registered arbiter, a copy model with an
// expected-write queue checked every cycle, and directed transfers with literal spot checks.
module tb_bus_dma_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic       busy;
    logic       done;
    logic       block;
    logic       r_arb;

    bus_dma_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    bus_dma_master #(.ADDR_W(8), .DATA_W(32), .LEN_W(8)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem [256];
    wr_t         q[$];
    int          n_chk  = 0;
    int          n_err  = 0;
    int          n_wr   = 0;
    int          n_done = 0;
    int          cyc    = 0;
    int          c0     = 0;
    int          d0     = 0;
    int          m_k    = 0;
    logic [7:0]  m_src  = 8'h00;
    bit          m_active = 1'b0;
    bit          chk_en   = 1'b0;

    function automatic logic [31:0] init_word(input int a);
        case (a)
            0:       return 32'hAAAA_0001;
            1:       return 32'hBBBB_0002;
            2:       return 32'hCCCC_0003;
            default: return 32'hD000_0000 | 32'(a << 8) | 32'(a);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Registered arbiter plus memory slave; block steals the grant for the other master
    assign bus.m_grant = r_arb && !block;
    assign bus.m_din   = mem[bus.m_address];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            r_arb <= 1'b0;
        end else begin
            r_arb <= bus.m_req;
            if (bus.m_req && bus.m_grant && bus.m_wr) begin
                mem[bus.m_address] <= bus.m_dout;
                n_wr <= n_wr + 1;
            end
        end
    end

    // Per-cycle comparison against the copy model
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("req_active", 32'(bus.m_req), 32'(m_active));
            chk("busy_active", 32'(busy), 32'(m_active));
            if (done) begin
                n_done++;
                chk("done_req_low", 32'(bus.m_req), 32'd0);
            end else if (!m_active) begin
                chk("idle_wr", 32'(bus.m_wr), 32'd0);
                chk("idle_addr", 32'(bus.m_address), 32'd0);
                chk("idle_dout", bus.m_dout, 32'd0);
            end
            if (bus.m_req && bus.m_grant) begin
                if (bus.m_wr) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL extra_write: got addr %h data %h expected none", bus.m_address, bus.m_dout);
                    end else begin
                        chk("wr_addr", 32'(bus.m_address), 32'(q[0].a));
                        chk("wr_data", bus.m_dout, q[0].d);
                        void'(q.pop_front());
                        m_k++;
                        if (q.size() == 0) m_active = 1'b0;
                    end
                end else begin
                    chk("rd_addr", 32'(bus.m_address), 32'(8'(m_src + 8'(m_k))));
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        logic [31:0] mm [256];
        logic [7:0]  ra;
        logic [7:0]  wa;
        wr_t         e;
        for (int i = 0; i < 256; i++) mm[i] = mem[i];
        q.delete();
        m_src = s;
        m_k   = 0;
        for (int i = 0; i < int'(l); i++) begin
            ra     = s + 8'(i);
            wa     = d + 8'(i);
            e.a    = wa;
            e.d    = mm[ra];
            mm[wa] = mm[ra];
            q.push_back(e);
        end
        d0 = n_done;
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = l;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = ~s;
        dst_addr = ~d;
        length   = l + 8'd5;
        m_active = (l != 8'd0);
        @(negedge clk);
        c0 = cyc;
    endtask

    task automatic finish_xfer(input int exp_lat);
        int lat;
        bit seen;
        lat  = -1;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                seen = 1'b1;
                lat  = cyc - c0 + 1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
        repeat (2) @(negedge clk);
        chk("done_once", 32'(n_done - d0), 32'd1);
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("req_after", 32'(bus.m_req), 32'd0);
    endtask

    task automatic wait_writes(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (n_wr == target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("write_reached", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(bus.m_req), 32'd0);
        chk({tag, "_wr"}, 32'(bus.m_wr), 32'd0);
        chk({tag, "_addr"}, 32'(bus.m_address), 32'd0);
        chk({tag, "_dout"}, bus.m_dout, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  w0;
        bit  hit;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = 8'h00;
        block    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Basic copy of A, B, C
        do_start(8'h00, 8'h20, 8'd3);
        finish_xfer(9);
        chk("basic_m20", mem[8'h20], 32'hAAAA_0001);
        chk("basic_m21", mem[8'h21], 32'hBBBB_0002);
        chk("basic_m22", mem[8'h22], 32'hCCCC_0003);

        // Zero length: done one cycle after start, no request
        do_start(8'h10, 8'h60, 8'd0);
        finish_xfer(1);
        chk("zero_m60", mem[8'h60], 32'hD000_6060);

        // Address wrap on the source side
        do_start(8'hFE, 8'h3E, 8'd3);
        finish_xfer(3 + 2 * 3);
        chk("wrap_m3e", mem[8'h3E], 32'hD000_FEFE);
        chk("wrap_m3f", mem[8'h3F], 32'hD000_FFFF);
        chk("wrap_m40", mem[8'h40], 32'hAAAA_0001);

        // Grant lost for 4 cycles during the second read
        do_start(8'h08, 8'h28, 8'd3);
        w0 = n_wr;
        wait_writes(w0 + 1);
        block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_addr", 32'(bus.m_address), 32'h09);
            chk("hold_req", 32'(bus.m_req), 32'd1);
            chk("hold_wr", 32'(bus.m_wr), 32'd0);
        end
        block = 1'b0;
        finish_xfer(0);
        chk("loss_writes", 32'(n_wr - w0), 32'd3);
        chk("loss_m29", mem[8'h29], 32'hD000_0909);
        chk("loss_m2a", mem[8'h2A], 32'hD000_0A0A);

        // Reset during the write of word 1, then a clean restart
        do_start(8'h50, 8'h70, 8'd4);
        w0 = n_wr;
        wait_writes(w0 + 1);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.m_wr) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reset_hit_write", 32'(hit), 32'd1);
        #1;
        reset    = 1'b1;
        m_active = 1'b0;
        q.delete();
        d0 = n_done;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_no_done", 32'(n_done - d0), 32'd0);
        do_start(8'h50, 8'h70, 8'd4);
        finish_xfer(3 + 2 * 4);
        chk("restart_m70", mem[8'h70], 32'hD000_5050);
        chk("restart_m73", mem[8'h73], 32'hD000_5353);

        // Start while busy is ignored
        do_start(8'h10, 8'h30, 8'd4);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        src_addr = 8'h80;
        dst_addr = 8'h90;
        length   = 8'd2;
        @(negedge clk);
        start = 1'b0;
        finish_xfer(3 + 2 * 4);
        chk("busy_m30", mem[8'h30], 32'hD000_1010);
        chk("busy_m33", mem[8'h33], 32'hD000_1313);
        chk("busy_m90", mem[8'h90], 32'hD000_9090);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
